// File: rtl/sync_fifo_rd.sv
// Synchronous FIFO: valid/ready enqueue, first-word-fall-through dequeue.
// Head entry is read combinationally; rst and flush both clear occupancy.
module sync_fifo_rd #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_enq_fire;
  logic w_deq_fire;
  logic w_clear;

  assign enq_ready  = (r_count != CNT_W'(DEPTH));
  assign deq_valid  = (r_count != '0);
  assign deq_data   = r_mem[r_head];
  assign count      = r_count;

  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;
  assign w_clear    = rst | flush;

  // Storage is deliberately not reset; only the written row is enabled.
  always_ff @(posedge clk) begin
    if (w_enq_fire && !w_clear) begin
      r_mem[r_tail] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_head <= r_head + PTR_W'(1);
      end
      unique case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_rd.sv
// Bench for sync_fifo_rd: directed plan then random traffic,
// checked against a queue-based reference model.
module tb_sync_fifo_rd;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_data;
  logic [CNT_W-1:0] count;

  int tests;
  int fails;

  logic [WIDTH-1:0] q[$];

  sync_fifo_rd #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs against the model, advance the model.
  task automatic cyc(input logic ev,
                     input logic [WIDTH-1:0] d,
                     input logic dr,
                     input logic fl = 1'b0,
                     input logic rs = 1'b0);
    logic fe;
    logic fd;
    int   n;
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    rst       = rs;
    #1;
    n = q.size();
    chk("count", WIDTH'(count), WIDTH'(n));
    chk("enq_ready", WIDTH'(enq_ready), WIDTH'(n != DEPTH));
    chk("deq_valid", WIDTH'(deq_valid), WIDTH'(n != 0));
    if (n != 0) chk("deq_data", deq_data, q[0]);
    fe = ev && (n < DEPTH);
    fd = dr && (n > 0);
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (fd) void'(q.pop_front());
      if (fe) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (3) cyc(1'b0, 32'h0, 1'b0);

    // Three in, three out, in order.
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);

    // Fill, then hold 0x99 against full while one entry leaves.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'hA0 + i, 1'b0);
    cyc(1'b1, 32'h99, 1'b1);
    cyc(1'b1, 32'h99, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'h0, 1'b1);

    // Steady state at four entries with both ports firing.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + i, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);

    // Flush at five entries with both handshakes offered.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h200 + i, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'hAB, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);

    // Reset mid-stream at six entries.
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h300 + i, 1'b0);
    cyc(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h400, 1'b0);
    cyc(1'b1, 32'h401, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom,
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 60) == 0),
          1'($urandom_range(0, 90) == 0));
    end
    repeat (DEPTH + 1) cyc(1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_rd.md
Name: sync_fifo_rd

Overview:
- Synchronous FIFO with a valid/ready enqueue port and a first-word-fall-through valid/ready dequeue port.
- It is the consumer/reader-side counterpart to the per-bit write-enabled storage flops.
- Storage is an array of write-enabled registers; the block adds head/tail pointers, occupancy tracking and the dequeue handshake.
- Used as the generic buffer between pipeline stages (e.g. fetch→decode, dispatch→issue queues).

Parameters:
- WIDTH, 32, bits per entry.
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all entries (pipeline squash).
- enq_valid  input  1  producer offers enq_data this cycle.
- enq_ready  output  1  FIFO can accept an entry this cycle.
- enq_data  input  WIDTH  entry to write.
- deq_valid  output  1  head entry available on deq_data.
- deq_ready  input  1  consumer takes the head entry this cycle.
- deq_data  output  WIDTH  head entry; combinational from storage[head].
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Handshakes:
  - enq fires = enq_valid & enq_ready.
  - deq fires = deq_valid & deq_ready.
  - Producer may hold enq_valid without ready; no data is lost or duplicated.
- Port signals:
  - enq_ready = (count != DEPTH). Purely state-based; does not depend on deq_ready, so there is no full-and-dequeue bypass.
  - deq_valid = (count != 0). Purely state-based; no empty-and-enqueue bypass.
- Enqueue: on enq fire, storage[tail] <= enq_data (write enable on that row only) and tail <= tail+1, wrapping modulo DEPTH.
- Dequeue: on deq fire, head <= head+1, wrapping modulo DEPTH. deq_data shows the new head the following cycle.
- count updates:
  - enq only: +1.
  - deq only: -1.
  - both, or neither: unchanged.
- Latency: an entry enqueued in cycle N is visible with deq_valid=1 in cycle N+1 (1-cycle fall-through).
- Full, enq_valid=1, deq_ready=1: only the dequeue fires; enq is accepted the next cycle (enq_ready=1 then).
- Empty, deq_ready=1: no dequeue; head and count unchanged.
- Empty, enq fires: deq_valid stays 0 this cycle and becomes 1 next cycle.
- Wrap-around: pointers roll DEPTH-1 → 0. Data order is strictly FIFO across the wrap.
- deq_data when deq_valid=0 is don't-care; the bench must not check it.
- flush=1:
  - Next state is head=0, tail=0, count=0.
  - Any enq or deq in the same cycle is discarded.
  - enq_ready and deq_valid still reflect pre-flush state during the flush cycle.
- rst=1:
  - Identical effect to flush; it has priority over flush and over both handshakes.
  - Reset values after the edge: count=0, deq_valid=0, enq_ready=1.
  - Storage contents are not reset.
  - Reset asserted mid-stream discards all entries; the first post-reset enqueue is returned first.
- rst and flush are sampled only at the clock edge. There is no asynchronous path.

Test Plan:
- Reset, then idle → after first edge count=0, deq_valid=0, enq_ready=1; stays so with no stimulus.
- Enqueue 0x11, 0x22, 0x33 back-to-back with deq_ready=0 → count=3. Then deq_ready=1 for 3 cycles → deq_data 0x11, 0x22, 0x33 in order, count back to 0, deq_valid=0.
- Fill with 8 entries (DEPTH=8) → enq_ready=0, count=8. Hold enq_valid=1 with data 0x99 plus one deq → 0x99 is accepted only on the following cycle and later dequeued 9th.
- Continuous simultaneous enq/deq at steady count=4 for 20 cycles → count stays 4, pointers wrap twice, output sequence equals input sequence delayed by 4 entries.
- With count=5, assert flush together with enq_valid=1 and deq_ready=1 → next cycle count=0, deq_valid=0. Next enqueue 0xAB is the first dequeued.
- Assert rst for one cycle mid-stream at count=6 with flush=0 → count=0, enq_ready=1, deq_valid=0. Old entries never reappear.
